// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I fetch stage owning the PC and the IF/ID register.
// Define IF_PERF_CNT_EN to add fetch_count_o / squash_count_o counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] out_i_imm,
   output logic [31:0] out_s_imm,
   output logic [31:0] out_b_imm,
   output logic [31:0] out_u_imm,
   output logic [31:0] out_j_imm
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count_o,
   output logic [31:0] squash_count_o
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_q, inflight_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        accept;
   logic [31:0] pc_inc;

   assign accept       = !out_valid_q || !stall_i;
   assign pc_inc       = pc_q + 32'd4;
   assign imem_read    = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_address = (state_q == DRAIN) ? inflight_q : pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inflight_d   = inflight_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (redirect_i) begin
         pc_d         = redirect_pc_i & 32'hFFFF_FFFC;
         out_valid_d  = 1'b0;
         out_pc_d     = '0;
         out_instr_d  = '0;
         skid_valid_d = 1'b0;
         unique case (state_q)
            IDLE, HOLD: state_d = FETCH;
            FETCH: begin
               // an unanswered request must still be drained before refetch
               if (imem_resp) begin
                  state_d = FETCH;
               end else begin
                  state_d    = DRAIN;
                  inflight_d = pc_q;
               end
            end
            DRAIN: state_d = imem_resp ? FETCH : DRAIN;
         endcase
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (imem_resp) begin
                  pc_d = pc_inc;
                  if (accept) begin
                     out_valid_d = 1'b1;
                     out_pc_d    = pc_q;
                     out_instr_d = imem_rdata;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_pc_d    = pc_q;
                     skid_instr_d = imem_rdata;
                     state_d      = HOLD;
                  end
               end else if (out_valid_q && !stall_i) begin
                  out_valid_d = 1'b0;
               end
            end
            DRAIN: begin
               if (imem_resp) state_d = FETCH;
            end
            HOLD: begin
               if (!stall_i) begin
                  out_valid_d  = skid_valid_q;
                  out_pc_d     = skid_pc_q;
                  out_instr_d  = skid_instr_q;
                  skid_valid_d = 1'b0;
                  state_d      = FETCH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inflight_q   <= '0;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_instr_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inflight_q   <= inflight_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_instr_q  <= out_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_pc_q;
   assign out_instr = out_instr_q;
   assign out_i_imm = {{20{out_instr_q[31]}}, out_instr_q[31:20]};
   assign out_s_imm = {{20{out_instr_q[31]}}, out_instr_q[31:25],
                       out_instr_q[11:7]};
   assign out_b_imm = {{19{out_instr_q[31]}}, out_instr_q[31],
                       out_instr_q[7], out_instr_q[30:25],
                       out_instr_q[11:8], 1'b0};
   assign out_u_imm = {out_instr_q[31:12], 12'b0};
   assign out_j_imm = {{11{out_instr_q[31]}}, out_instr_q[31],
                       out_instr_q[19:12], out_instr_q[20],
                       out_instr_q[30:21], 1'b0};

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, squash_cnt_q;
   logic        load_evt;
   logic        rsp_live;
   logic [1:0]  squash_evt;

   assign rsp_live = imem_resp && imem_read;
   assign load_evt = !redirect_i &&
                     (((state_q == FETCH) && imem_resp && accept) ||
                      ((state_q == HOLD) && !stall_i && skid_valid_q));
   // flushed output, flushed skid and dropped response each count once
   assign squash_evt = redirect_i ?
                       (2'(out_valid_q) + 2'(skid_valid_q) + 2'(rsp_live)) :
                       2'((state_q == DRAIN) && imem_resp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_q + {31'b0, load_evt};
         squash_cnt_q <= squash_cnt_q + {30'b0, squash_evt};
      end
   end

   assign fetch_count_o  = fetch_cnt_q;
   assign squash_count_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: immediate vectors, directed stall/redirect/reset
// sequences and a randomized run against a program-order scoreboard.
module tb_if_fetch_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0060;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        out_valid;
   logic [31:0] out_pc, out_instr;
   logic [31:0] out_i_imm, out_s_imm, out_b_imm, out_u_imm, out_j_imm;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count_o, squash_count_o;
`endif

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_i_imm(out_i_imm), .out_s_imm(out_s_imm),
      .out_b_imm(out_b_imm), .out_u_imm(out_u_imm),
      .out_j_imm(out_j_imm)
`ifdef IF_PERF_CNT_EN
      , .fetch_count_o(fetch_count_o), .squash_count_o(squash_count_o)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      int          fld;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [8];
   int          ntbl = 8;
   int          checks = 0;
   int          errors = 0;
   int          mode, lat_mode, lat, lat_cnt, consumed;
   bit          sb_en;
   logic [31:0] exp_pc;
   logic        p_hold, p_redir, p_pend;
   logic [31:0] p_pc, p_instr, p_addr;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // immediates rebuilt with shifts and masks from the ISA bit layout
   function automatic logic [31:0] imm_of(input int f, input logic [31:0] x);
      logic [31:0] sx;
      sx = $signed(x) >>> 31;
      case (f)
         0: return $signed(x) >>> 20;
         1: return ((sx << 12) | (((x >> 25) & 32'h7F) << 5) |
                    ((x >> 7) & 32'h1F));
         2: return ((sx << 12) | (((x >> 7) & 32'h1) << 11) |
                    (((x >> 25) & 32'h3F) << 5) | (((x >> 8) & 32'hF) << 1));
         3: return x & 32'hFFFF_F000;
         default: return ((sx << 20) | (x & 32'h000F_F000) |
                          (((x >> 20) & 32'h1) << 11) |
                          (((x >> 21) & 32'h3FF) << 1));
      endcase
   endfunction

   function automatic logic [31:0] dut_imm(input int f);
      case (f)
         0: return out_i_imm;
         1: return out_s_imm;
         2: return out_b_imm;
         3: return out_u_imm;
         default: return out_j_imm;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] idx;
      if (mode == 0) begin
         idx = (a - RST_PC) >> 2;
         if (a >= RST_PC && idx < 32'(ntbl)) return tbl[idx].instr;
         return 32'h0000_0013;
      end
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic mem_drive();
      if (imem_read) begin
         if (lat_cnt == 0 && lat_mode == 1) lat = $urandom_range(1, 3);
         if (lat_cnt >= lat - 1) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(imem_address);
            lat_cnt    = 0;
         end else begin
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
            lat_cnt++;
         end
      end else begin
         imem_resp  = 1'b0;
         imem_rdata = $urandom;
         lat_cnt    = 0;
      end
   endtask

   task automatic scoreboard();
      if (p_hold) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_pc", out_pc, p_pc);
         chk("hold_instr", out_instr, p_instr);
      end
      if (p_redir) begin
         chk("flush_valid", 32'(out_valid), 32'd0);
         chk("flush_imm", out_i_imm | out_s_imm | out_b_imm |
             out_u_imm | out_j_imm, 32'd0);
      end
      if (p_pend) begin
         chk("req_held", 32'(imem_read), 32'd1);
         chk("req_addr", imem_address, p_addr);
      end
      if (redirect_i) begin
         exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (out_valid && !stall_i) begin
         chk("sb_pc", out_pc, exp_pc);
         chk("sb_instr", out_instr, mem_word(exp_pc));
         for (int f = 0; f < 5; f++)
            chk("sb_imm", dut_imm(f), imm_of(f, out_instr));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      p_hold  = out_valid && stall_i && !redirect_i;
      p_pc    = out_pc;
      p_instr = out_instr;
      p_redir = redirect_i;
      p_pend  = imem_read && !imem_resp;
      p_addr  = imem_address;
   endtask

   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      mem_drive();
      @(negedge clk);
      if (sb_en) scoreboard();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      imem_resp = 1'b0; imem_rdata = '0; lat_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read", 32'(imem_read), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_imm", out_i_imm | out_s_imm | out_b_imm |
          out_u_imm | out_j_imm, 32'd0);
      rst = 1'b0;
      exp_pc = RST_PC; consumed = 0;
      p_hold = 0; p_redir = 0; p_pend = 0; p_pc = '0; p_instr = '0; p_addr = '0;
      @(negedge clk);
      chk("first_cycle_read", 32'(imem_read), 32'd0);
   endtask

   initial begin
      tbl[0] = '{32'h0000_0013, 0, 32'h0000_0000};
      tbl[1] = '{32'hFE00_0EE3, 2, 32'hFFFF_FFFC};
      tbl[2] = '{32'h0080_00EF, 4, 32'h0000_0008};
      tbl[3] = '{32'hFFF0_0093, 0, 32'hFFFF_FFFF};
      tbl[4] = '{32'h1234_5037, 3, 32'h1234_5000};
      tbl[5] = '{32'hFE11_2E23, 1, 32'hFFFF_FFFC};
      tbl[6] = '{32'h8000_00B7, 3, 32'h8000_0000};
      tbl[7] = '{32'hFFDF_F06F, 4, 32'hFFFF_FFFC};
      sb_en = 1;

      // immediate vectors streamed from a 1-cycle memory
      mode = 0; lat_mode = 0; lat = 1;
      do_reset();
      for (int k = 0; k <= ntbl; k++) begin
         step(0, 0, 0);
         if (k < ntbl) chk("tbl_addr", imem_address, RST_PC + 32'(4 * k));
         if (k > 0) begin
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_pc", out_pc, RST_PC + 32'(4 * (k - 1)));
            chk("tbl_instr", out_instr, tbl[k-1].instr);
            chk("tbl_imm", dut_imm(tbl[k-1].fld), tbl[k-1].exp);
         end
      end

      // stall with a response in flight goes through the skid
      do_reset();
      step(0, 0, 0);
      step(1, 0, 0);
      chk("stl_valid", 32'(out_valid), 32'd1);
      chk("stl_pc", out_pc, 32'h60);
      chk("stl_addr", imem_address, 32'h64);
      chk("stl_resp", 32'(imem_resp), 32'd1);
      step(1, 0, 0);
      chk("hold_read", 32'(imem_read), 32'd0);
      chk("hold_pc0", out_pc, 32'h60);
      step(1, 0, 0);
      chk("hold_read2", 32'(imem_read), 32'd0);
      step(0, 0, 0);
      chk("rel_pc", out_pc, 32'h60);
      step(0, 0, 0);
      chk("skid_pc", out_pc, 32'h64);
      chk("skid_valid", 32'(out_valid), 32'd1);
      chk("resume_read", 32'(imem_read), 32'd1);
      chk("resume_addr", imem_address, 32'h68);

      // redirect while a 3-cycle request is outstanding
      lat = 3;
      do_reset();
      repeat (4) step(0, 0, 0);
      chk("lat3_pc", out_pc, 32'h60);
      step(0, 1, 32'h200);
      chk("drn_addr0", imem_address, 32'h64);
      chk("drn_noresp", 32'(imem_resp), 32'd0);
      step(0, 0, 0);
      chk("drn_addr1", imem_address, 32'h64);
      chk("drn_resp", 32'(imem_resp), 32'd1);
      chk("drn_valid", 32'(out_valid), 32'd0);
      step(0, 0, 0);
      chk("drn_newaddr", imem_address, 32'h200);
      chk("drn_discard", 32'(out_valid), 32'd0);
      for (int n = 0; n < 10 && !out_valid; n++) step(0, 0, 0);
      chk("drn_arrive", 32'(out_valid), 32'd1);
      chk("drn_tgt_pc", out_pc, 32'h200);

      // async reset while draining
      step(0, 1, 32'h300);
      chk("drn2_noresp", 32'(imem_resp), 32'd0);
      @(posedge clk);
      #1;
      chk("drn2_read", 32'(imem_read), 32'd1);
      chk("drn2_addr", imem_address, 32'h204);
      #2 rst = 1'b1;
      #1;
      chk("arst_read", 32'(imem_read), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_instr", out_instr, 32'd0);
      chk("arst_pc", out_pc, 32'd0);
      do_reset();
      step(0, 0, 0);
      chk("arst_first", imem_address, 32'h60);

      // same-cycle redirect and PC wrap
      lat = 1;
      do_reset();
      step(0, 0, 0);
      step(0, 1, 32'h103);
      chk("sc_resp", 32'(imem_resp), 32'd1);
      chk("sc_addr", imem_address, 32'h64);
      step(0, 0, 0);
      chk("sc_newaddr", imem_address, 32'h100);
      chk("sc_valid", 32'(out_valid), 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("sc_fetch_cnt", fetch_count_o, 32'd1);
      chk("sc_squash_cnt", squash_count_o, 32'd2);
`endif
      step(0, 1, 32'hFFFF_FFFE);
      chk("sc_pc", out_pc, 32'h100);
      step(0, 0, 0);
      chk("wrap_addr0", imem_address, 32'hFFFF_FFFC);
      step(0, 0, 0);
      chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_addr1", imem_address, 32'h0);
      step(0, 0, 0);
      chk("wrap_pc0", out_pc, 32'h0);

      // randomized traffic against the scoreboard
      mode = 1; lat_mode = 1;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        st, rd;
         logic [31:0] rpc;
         st  = ($urandom % 10) < 3;
         rd  = ($urandom % 100) < 6;
         rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16))
                                     : $urandom;
         step(st, rd, rpc);
      end
      chk("liveness", 32'(consumed > 200), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
